// File: rtl/fpu_stall_ctrl.sv
// fpu_stall_ctrl: pipeline hold, bubble and result-valid control
// for multi-cycle FPU operations sitting in EX.
//
// Ports:
//   clk50M         : system clock, rising edge
//   rst            : async reset, active low
//   fpu_start_i    : valid FP instruction in EX this cycle
//   fpu_op_i[2:0]  : op class (1xx = single-cycle)
//   flush_i        : pipeline flush, highest priority
//   stall_o        : hold IF/ID and ID/EX (enable pins)
//   bubble_o       : load NOP into EX/MEM
//   result_valid_o : one-cycle write-back pulse
//   busy_o         : FSM is in BUSY (registered)
//   op_o[2:0]      : op class in flight (registered)
module fpu_stall_ctrl #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       fpu_start_i,
  input  logic [2:0] fpu_op_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       bubble_o,
  output logic       result_valid_o,
  output logic       busy_o,
  output logic [2:0] op_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [2:0]         op_q;
  logic [2:0]         op_n;
  logic [CNT_W-1:0]   lat;
  logic               stall;
  logic               bubble;
  logic               valid;

  always_comb begin
    lat = CNT_W'(1);
    if (!fpu_op_i[2]) begin
      unique case (fpu_op_i[1:0])
        2'b00: lat = CNT_W'(LAT_ADD);
        2'b01: lat = CNT_W'(LAT_MUL);
        2'b10: lat = CNT_W'(LAT_DIV);
        2'b11: lat = CNT_W'(LAT_SQRT);
      endcase
    end
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    valid   = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fpu_start_i) begin
            if (lat == CNT_W'(1)) begin
              valid = 1'b1;
            end else begin
              stall   = 1'b1;
              bubble  = 1'b1;
              cnt_n   = lat - CNT_W'(2);
              op_n    = fpu_op_i;
              state_n = BUSY;
            end
          end
        end
        BUSY: begin
          // start is ignored here: the same instruction is still in EX
          if (cnt != '0) begin
            stall  = 1'b1;
            bubble = 1'b1;
            cnt_n  = cnt - CNT_W'(1);
          end else begin
            valid   = 1'b1;
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  // reset gates the combinational outputs so nothing leaks while rst is low
  assign stall_o        = rst & stall;
  assign bubble_o       = rst & bubble;
  assign result_valid_o = rst & valid;
  assign busy_o         = (state == BUSY);
  assign op_o           = op_q;

endmodule

// File: tb/tb_fpu_stall_ctrl.sv
// tb_fpu_stall_ctrl: vector table, directed multi-cycle sequences
// and random stimulus against a cycle-level latency model.
module tb_fpu_stall_ctrl;

  logic       clk50M = 1'b0;
  logic       rst = 1'b0;
  logic       fpu_start_i = 1'b0;
  logic [2:0] fpu_op_i = 3'b000;
  logic       flush_i = 1'b0;
  logic       stall_o;
  logic       bubble_o;
  logic       result_valid_o;
  logic       busy_o;
  logic [2:0] op_o;

  int errors = 0;
  int checks = 0;

  fpu_stall_ctrl dut (
    .clk50M         (clk50M),
    .rst            (rst),
    .fpu_start_i    (fpu_start_i),
    .fpu_op_i       (fpu_op_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .bubble_o       (bubble_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o),
    .op_o           (op_o)
  );

  always #10 clk50M = ~clk50M;

  // model: an op in flight, how many cycles it has spent in EX,
  // its total latency, and the captured op class
  bit       m_fly;
  int       m_el;
  int       m_lat;
  bit [2:0] m_op;
  bit       n_fly;
  int       n_el;
  int       n_lat;
  bit [2:0] n_op;
  bit       e_st, e_bb, e_vl, e_bz;
  bit [2:0] e_op;

  function automatic int lat_of(input bit [2:0] op);
    if (op[2]) return 1;
    case (op[1:0])
      2'b00:   return 3;
      2'b01:   return 4;
      2'b10:   return 12;
      default: return 16;
    endcase
  endfunction

  task automatic mreset();
    m_fly = 0; m_el = 0; m_lat = 0; m_op = 3'b000;
  endtask

  task automatic model_comb();
    if (!rst) mreset();
    n_fly = m_fly; n_el = m_el; n_lat = m_lat; n_op = m_op;
    e_st = 0; e_bb = 0; e_vl = 0;
    e_bz = m_fly; e_op = m_op;
    if (!rst) begin
      n_fly = 0;
    end else if (flush_i) begin
      n_fly = 0;
    end else if (!m_fly) begin
      if (fpu_start_i) begin
        if (lat_of(fpu_op_i) == 1) begin
          e_vl = 1;
        end else begin
          e_st = 1; e_bb = 1;
          n_fly = 1; n_el = 1;
          n_lat = lat_of(fpu_op_i);
          n_op = fpu_op_i;
        end
      end
    end else if (m_el == m_lat - 1) begin
      e_vl = 1;
      n_fly = 0;
    end else begin
      e_st = 1; e_bb = 1;
      n_el = m_el + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic setin(input bit r, input bit s,
                       input bit [2:0] op, input bit f);
    @(negedge clk50M);
    rst = r; fpu_start_i = s; fpu_op_i = op; flush_i = f;
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk50M);
    m_fly = n_fly; m_el = n_el; m_lat = n_lat; m_op = n_op;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".stall"}, {2'b0, stall_o}, {2'b0, e_st});
    chk({nm, ".bubble"}, {2'b0, bubble_o}, {2'b0, e_bb});
    chk({nm, ".valid"}, {2'b0, result_valid_o}, {2'b0, e_vl});
    chk({nm, ".busy"}, {2'b0, busy_o}, {2'b0, e_bz});
    chk({nm, ".op"}, op_o, e_op);
  endtask

  typedef struct {
    bit       r, s;
    bit [2:0] op;
    bit       f;
    bit       st, bb, vl, bz;
    bit [2:0] oo;
  } vec_t;

  vec_t tbl[16];
  int   sc, vc;

  initial begin
    mreset();
    tbl[0]  = '{0, 1, 3'b001, 0, 0, 0, 0, 0, 3'b000};
    tbl[1]  = '{1, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000};
    tbl[2]  = '{1, 1, 3'b001, 0, 1, 1, 0, 0, 3'b000};
    tbl[3]  = '{1, 0, 3'b000, 0, 1, 1, 0, 1, 3'b001};
    tbl[4]  = '{1, 0, 3'b000, 0, 1, 1, 0, 1, 3'b001};
    tbl[5]  = '{1, 0, 3'b000, 0, 0, 0, 1, 1, 3'b001};
    tbl[6]  = '{1, 1, 3'b100, 0, 0, 0, 1, 0, 3'b001};
    tbl[7]  = '{1, 0, 3'b000, 0, 0, 0, 0, 0, 3'b001};
    tbl[8]  = '{1, 1, 3'b000, 0, 1, 1, 0, 0, 3'b001};
    tbl[9]  = '{1, 1, 3'b011, 0, 1, 1, 0, 1, 3'b000};
    tbl[10] = '{1, 0, 3'b000, 0, 0, 0, 1, 1, 3'b000};
    tbl[11] = '{1, 1, 3'b001, 1, 0, 0, 0, 0, 3'b000};
    tbl[12] = '{1, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000};
    tbl[13] = '{1, 1, 3'b011, 0, 1, 1, 0, 0, 3'b000};
    tbl[14] = '{1, 0, 3'b000, 1, 0, 0, 0, 1, 3'b011};
    tbl[15] = '{1, 0, 3'b000, 0, 0, 0, 0, 0, 3'b011};

    for (int i = 0; i < 16; i++) begin
      setin(tbl[i].r, tbl[i].s, tbl[i].op, tbl[i].f);
      chk($sformatf("tbl%0d.stall", i), {2'b0, stall_o}, {2'b0, tbl[i].st});
      chk($sformatf("tbl%0d.bubble", i), {2'b0, bubble_o}, {2'b0, tbl[i].bb});
      chk($sformatf("tbl%0d.valid", i), {2'b0, result_valid_o},
          {2'b0, tbl[i].vl});
      chk($sformatf("tbl%0d.busy", i), {2'b0, busy_o}, {2'b0, tbl[i].bz});
      chk($sformatf("tbl%0d.op", i), op_o, tbl[i].oo);
      tick();
    end

    // DIV then ADD back-to-back
    sc = 0; vc = 0;
    setin(1, 1, 3'b010, 0); check_model("div"); sc += int'(stall_o);
    tick();
    for (int i = 0; i < 11; i++) begin
      setin(1, 0, 3'b000, 0); check_model("div");
      sc += int'(stall_o); vc += int'(result_valid_o);
      tick();
    end
    chk("div.stall_cycles", 3'(sc), 3'(11 % 8));
    checks++;
    if (sc != 11) begin
      errors++;
      $display("FAIL div.stall_total: got %0d expected 11", sc);
    end
    chk("div.valid_pulses", 3'(vc), 3'd1);
    sc = 0; vc = 0;
    setin(1, 1, 3'b000, 0); check_model("add"); sc += int'(stall_o);
    tick();
    for (int i = 0; i < 3; i++) begin
      setin(1, 0, 3'b000, 0); check_model("add");
      sc += int'(stall_o); vc += int'(result_valid_o);
      tick();
    end
    chk("add.stall_cycles", 3'(sc), 3'd2);
    chk("add.valid_pulses", 3'(vc), 3'd1);

    // flush at T+5 during SQRT
    vc = 0;
    setin(1, 1, 3'b011, 0); check_model("sqrt"); tick();
    for (int i = 0; i < 4; i++) begin
      setin(1, 0, 3'b000, 0); check_model("sqrt");
      vc += int'(result_valid_o); tick();
    end
    setin(1, 0, 3'b000, 1); check_model("sqrt.flush");
    chk("sqrt.flush_stall", {2'b0, stall_o}, 3'd0);
    tick();
    setin(1, 0, 3'b000, 0); check_model("sqrt.after");
    chk("sqrt.idle_after", {2'b0, busy_o}, 3'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      setin(1, 0, 3'b000, 0); check_model("sqrt.tail");
      vc += int'(result_valid_o); tick();
    end
    chk("sqrt.no_valid", 3'(vc), 3'd0);

    // async reset between edges mid-DIV
    setin(1, 1, 3'b010, 0); check_model("div2"); tick();
    for (int i = 0; i < 3; i++) begin
      setin(1, 0, 3'b000, 0); check_model("div2"); tick();
    end
    #2;
    rst = 1'b0;
    fpu_start_i = 1'b1;
    mreset();
    #1;
    chk("arst.stall", {2'b0, stall_o}, 3'd0);
    chk("arst.bubble", {2'b0, bubble_o}, 3'd0);
    chk("arst.valid", {2'b0, result_valid_o}, 3'd0);
    chk("arst.busy", {2'b0, busy_o}, 3'd0);
    chk("arst.op", op_o, 3'd0);
    setin(0, 1, 3'b010, 0); check_model("arst.hold"); tick();
    sc = 0; vc = 0;
    setin(1, 1, 3'b000, 0); check_model("add2"); sc += int'(stall_o);
    tick();
    for (int i = 0; i < 3; i++) begin
      setin(1, 0, 3'b000, 0); check_model("add2");
      sc += int'(stall_o); vc += int'(result_valid_o);
      tick();
    end
    chk("add2.stall_cycles", 3'(sc), 3'd2);
    chk("add2.valid_pulses", 3'(vc), 3'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      setin($urandom_range(49) != 0, $urandom_range(1) == 1,
            3'($urandom_range(7)), $urandom_range(15) == 0);
      check_model("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
